// File: rtl/tcdm_interco_pkg.sv
// rtl/tcdm_interco_pkg.sv - shared index-width helper and response pipeline stage type
package tcdm_interco_pkg;

    // Wide enough for the largest legal master count (256).
    localparam int MaxIdxWidth = 8;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [MaxIdxWidth-1:0] idx;
    } resp_stage_t;

endpackage

// File: rtl/bank_arb_resp_demux_if.sv
// rtl/bank_arb_resp_demux_if.sv - master-side and bank-side signal bundle for the arbiter
interface bank_arb_resp_demux_if #(
    parameter int NumMaster     = 32,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32
);
    logic [NumMaster-1:0]                   req;
    logic [NumMaster-1:0][ReqDataWidth-1:0] data;
    logic [NumMaster-1:0]                   gnt;
    logic [NumMaster-1:0]                   rvld;
    logic [RespDataWidth-1:0]               rdata;
    logic                                   bank_req;
    logic                                   bank_gnt;
    logic [ReqDataWidth-1:0]                bank_data;
    logic [RespDataWidth-1:0]               bank_rdata;

    modport master (
        output req, data, bank_gnt, bank_rdata,
        input  gnt, rvld, rdata, bank_req, bank_data
    );

    modport slave (
        input  req, data, bank_gnt, bank_rdata,
        output gnt, rvld, rdata, bank_req, bank_data
    );
endinterface

// File: rtl/bank_rr_arbiter.sv
// rtl/bank_rr_arbiter.sv - round-robin winner selection with handshake-qualified pointer
module bank_rr_arbiter
    import tcdm_interco_pkg::*;
#(
    parameter int NumMaster = 32,
    localparam int IdxWidth = idx_width(NumMaster)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumMaster-1:0] req,
    input  logic                 gnt,
    output logic [IdxWidth-1:0]  win_idx,
    output logic                 win_valid,
    output logic                 hs,
    output logic [IdxWidth-1:0]  ptr_next,
    output logic [IdxWidth-1:0]  ptr_q
);

    int cand;

    // Scan from the highest offset down so the lowest offset above the pointer wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = NumMaster - 1; i >= 0; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= NumMaster) cand = cand - NumMaster;
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = IdxWidth'(cand);
            end
        end
    end

    assign hs       = win_valid & gnt;
    assign ptr_next = (win_idx == IdxWidth'(NumMaster - 1)) ? '0 : win_idx + IdxWidth'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (hs) begin
            ptr_q <= ptr_next;
        end
    end

endmodule

// File: rtl/bank_arb_resp_demux.sv
// rtl/bank_arb_resp_demux.sv - N-to-1 bank arbiter with latency-matched response demux
module bank_arb_resp_demux
    import tcdm_interco_pkg::*;
#(
    parameter int NumMaster     = 32,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32,
    parameter int RespLat       = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumMaster-1:0]                   req_i,
    input  logic [NumMaster-1:0][ReqDataWidth-1:0] data_i,
    output logic [NumMaster-1:0]                   gnt_o,
    output logic [NumMaster-1:0]                   rvld_o,
    output logic [RespDataWidth-1:0]               rdata_o,
    output logic                                   req_o,
    input  logic                                   gnt_i,
    output logic [ReqDataWidth-1:0]                data_o,
    input  logic [RespDataWidth-1:0]               rdata_i
);

    localparam int IdxWidth = idx_width(NumMaster);

    logic [IdxWidth-1:0] win_idx;
    logic                win_valid;
    logic                hs;
    logic [IdxWidth-1:0] ptr_next;
    logic [IdxWidth-1:0] ptr_q;
    resp_stage_t         pipe_q [RespLat];
    resp_stage_t         last_stage;

    bank_rr_arbiter #(
        .NumMaster (NumMaster)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req       (req_i),
        .gnt       (gnt_i),
        .win_idx   (win_idx),
        .win_valid (win_valid),
        .hs        (hs),
        .ptr_next  (ptr_next),
        .ptr_q     (ptr_q)
    );

    assign req_o   = |req_i;
    assign data_o  = data_i[win_idx];
    assign rdata_o = rdata_i;

    always_comb begin
        gnt_o = '0;
        if (win_valid) gnt_o[win_idx] = gnt_i;
    end

    // Each stage carries the granted master so the response lands on the right rvld bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < RespLat; s++) pipe_q[s] <= '0;
        end else begin
            pipe_q[0].valid <= hs;
            pipe_q[0].idx   <= MaxIdxWidth'(win_idx);
            for (int s = 1; s < RespLat; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign last_stage = pipe_q[RespLat-1];

    always_comb begin
        rvld_o = '0;
        if (last_stage.valid) rvld_o[last_stage.idx[IdxWidth-1:0]] = 1'b1;
    end

endmodule

// File: tb/tb_bank_arb_resp_demux.sv
// tb/tb_bank_arb_resp_demux.sv - directed table-driven bench for bank_arb_resp_demux
module tb_bank_arb_resp_demux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bank_arb_resp_demux_if #(.NumMaster(4), .ReqDataWidth(32), .RespDataWidth(32)) ifa ();
    bank_arb_resp_demux_if #(.NumMaster(4), .ReqDataWidth(32), .RespDataWidth(32)) ifb ();
    bank_arb_resp_demux_if #(.NumMaster(4), .ReqDataWidth(32), .RespDataWidth(32)) ifc ();

    bank_arb_resp_demux #(.NumMaster(4), .ReqDataWidth(32), .RespDataWidth(32), .RespLat(1)) ua (
        .clk_i(clk), .rst_i(rst), .req_i(ifa.req), .data_i(ifa.data), .gnt_o(ifa.gnt),
        .rvld_o(ifa.rvld), .rdata_o(ifa.rdata), .req_o(ifa.bank_req), .gnt_i(ifa.bank_gnt),
        .data_o(ifa.bank_data), .rdata_i(ifa.bank_rdata));

    bank_arb_resp_demux #(.NumMaster(4), .ReqDataWidth(32), .RespDataWidth(32), .RespLat(3)) ub (
        .clk_i(clk), .rst_i(rst), .req_i(ifb.req), .data_i(ifb.data), .gnt_o(ifb.gnt),
        .rvld_o(ifb.rvld), .rdata_o(ifb.rdata), .req_o(ifb.bank_req), .gnt_i(ifb.bank_gnt),
        .data_o(ifb.bank_data), .rdata_i(ifb.bank_rdata));

    bank_arb_resp_demux #(.NumMaster(4), .ReqDataWidth(32), .RespDataWidth(32), .RespLat(2)) uc (
        .clk_i(clk), .rst_i(rst), .req_i(ifc.req), .data_i(ifc.data), .gnt_o(ifc.gnt),
        .rvld_o(ifc.rvld), .rdata_o(ifc.rdata), .req_o(ifc.bank_req), .gnt_i(ifc.bank_gnt),
        .data_o(ifc.bank_data), .rdata_i(ifc.bank_rdata));

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       gnt;
        logic [3:0] exp_gnt;
        logic       exp_breq;
        logic [1:0] exp_win;
        logic [3:0] exp_rvld;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs [24];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic r, logic [3:0] q, logic g, logic [3:0] eg, logic eb,
                                logic [1:0] ew, logic [3:0] ev, logic [1:0] ep);
        vec_t v;
        v.rst = r; v.req = q; v.gnt = g; v.exp_gnt = eg; v.exp_breq = eb;
        v.exp_win = ew; v.exp_rvld = ev; v.exp_ptr = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic g, input logic [31:0] rd);
        rst = r;
        ifa.req = q; ifb.req = q; ifc.req = q;
        ifa.bank_gnt = g; ifb.bank_gnt = g; ifc.bank_gnt = g;
        ifa.bank_rdata = rd; ifb.bank_rdata = rd; ifc.bank_rdata = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] s_req [7];
    logic       s_gnt [7];
    logic [3:0] s_ga  [7];
    logic [3:0] s_va  [7];
    logic [3:0] s_vb  [7];

    initial begin
        for (int m = 0; m < 4; m++) begin
            ifa.data[m] = 32'hA0 + m; ifb.data[m] = 32'hA0 + m; ifc.data[m] = 32'hA0 + m;
        end
        drive(1'b1, 4'b0000, 1'b0, 32'h0);

        vecs[0]  = mk(1, 4'b0100, 1, 4'b0100, 1, 2, 4'b0000, 0);
        vecs[1]  = mk(0, 4'b1010, 1, 4'b0010, 1, 1, 4'b0000, 0);
        vecs[2]  = mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0010, 2);
        vecs[3]  = mk(1, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 2);
        vecs[4]  = mk(0, 4'b1111, 1, 4'b0001, 1, 0, 4'b0000, 0);
        vecs[5]  = mk(0, 4'b1111, 1, 4'b0010, 1, 1, 4'b0001, 1);
        vecs[6]  = mk(0, 4'b1111, 1, 4'b0100, 1, 2, 4'b0010, 2);
        vecs[7]  = mk(0, 4'b1111, 1, 4'b1000, 1, 3, 4'b0100, 3);
        vecs[8]  = mk(0, 4'b1111, 1, 4'b0001, 1, 0, 4'b1000, 0);
        vecs[9]  = mk(0, 4'b1111, 1, 4'b0010, 1, 1, 4'b0001, 1);
        vecs[10] = mk(0, 4'b1111, 1, 4'b0100, 1, 2, 4'b0010, 2);
        vecs[11] = mk(0, 4'b1111, 1, 4'b1000, 1, 3, 4'b0100, 3);
        vecs[12] = mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b1000, 0);
        vecs[13] = mk(0, 4'b0100, 0, 4'b0000, 1, 2, 4'b0000, 0);
        vecs[14] = mk(0, 4'b0100, 0, 4'b0000, 1, 2, 4'b0000, 0);
        vecs[15] = mk(0, 4'b0100, 0, 4'b0000, 1, 2, 4'b0000, 0);
        vecs[16] = mk(0, 4'b0100, 1, 4'b0100, 1, 2, 4'b0000, 0);
        vecs[17] = mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0100, 3);
        vecs[18] = mk(0, 4'b0001, 1, 4'b0001, 1, 0, 4'b0000, 3);
        vecs[19] = mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0001, 1);
        vecs[20] = mk(0, 4'b1001, 0, 4'b0000, 1, 3, 4'b0000, 1);
        vecs[21] = mk(0, 4'b0001, 0, 4'b0000, 1, 0, 4'b0000, 1);
        vecs[22] = mk(0, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 1);
        vecs[23] = mk(0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 1);

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].gnt, 32'h1234_0000 + i);
            #2;
            check($sformatf("v%0d gnt", i), 32'(ifa.gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("v%0d bank_req", i), 32'(ifa.bank_req), 32'(vecs[i].exp_breq));
            check($sformatf("v%0d rvld", i), 32'(ifa.rvld), 32'(vecs[i].exp_rvld));
            check($sformatf("v%0d ptr", i), 32'(ua.u_arb.ptr_q), 32'(vecs[i].exp_ptr));
            check($sformatf("v%0d rdata", i), ifa.rdata, 32'h1234_0000 + i);
            if (vecs[i].exp_breq)
                check($sformatf("v%0d data", i), ifa.bank_data, 32'hA0 + 32'(vecs[i].exp_win));
            next_cycle();
        end

        // Back-to-back handshakes from masters 3, 0, 2 against latencies 1 and 3.
        s_req = '{4'b1000, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        s_gnt = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        s_ga  = '{4'b1000, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        s_va  = '{4'b0000, 4'b1000, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        s_vb  = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0100, 4'b0000};
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, s_req[k], s_gnt[k], 32'h0);
            #2;
            check($sformatf("b2b%0d gnt", k), 32'(ifa.gnt), 32'(s_ga[k]));
            check($sformatf("b2b%0d rvld_lat1", k), 32'(ifa.rvld), 32'(s_va[k]));
            check($sformatf("b2b%0d rvld_lat3", k), 32'(ifb.rvld), 32'(s_vb[k]));
            next_cycle();
        end

        // Handshake then a one-cycle reset: the latency-2 response must never appear.
        drive(1'b0, 4'b0010, 1'b1, 32'h0);
        #2;
        check("rst_mid gnt", 32'(ifc.gnt), 32'h2);
        next_cycle();
        drive(1'b1, 4'b0000, 1'b0, 32'h0);
        #2;
        check("rst_mid rvld_lat2 c1", 32'(ifc.rvld), 32'h0);
        check("rst_mid rvld_lat1 c1", 32'(ifa.rvld), 32'h2);
        next_cycle();
        drive(1'b0, 4'b0000, 1'b0, 32'h0);
        #2;
        check("rst_mid rvld_lat2 c2", 32'(ifc.rvld), 32'h0);
        check("rst_mid ptr", 32'(uc.u_arb.ptr_q), 32'h0);
        next_cycle();
        #2;
        check("rst_mid rvld_lat2 c3", 32'(ifc.rvld), 32'h0);
        check("rst_mid rvld_lat3 c3", 32'(ifb.rvld), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
